// File: rtl/nchan_mux_arb.sv
// nchan_mux_arb: N-channel valid/ready arbiter feeding one registered output.
// The output register loads the granted channel's word in the same cycle it
// frees up, so back-to-back traffic moves one word per cycle.
// Define NCHAN_MUX_ARB_RR_EN for round-robin arbitration; otherwise the
// lowest-index valid channel wins.
// Ports:
//   clock, reset_n       rising-edge clock, async active-low reset
//   in_data[N*WIDTH]     channel i in bits [i*WIDTH +: WIDTH]
//   in_valid[N]          per-channel valid
//   in_ready[N]          per-channel ready, one-hot or zero
//   out_data[WIDTH]      registered selected word
//   out_valid, out_ready output handshake
//   out_sel              index of the channel that supplied out_data
module nchan_mux_arb #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic [N*WIDTH-1:0]                   in_data,
  input  logic [N-1:0]                         in_valid,
  output logic [N-1:0]                         in_ready,
  output logic [WIDTH-1:0]                     out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_sel
);

  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [WIDTH-1:0] r_data;
  logic [SW-1:0]    r_sel;
  logic             r_valid;

  logic [SW-1:0]    w_ptr;
  logic [SW-1:0]    w_gidx;
  logic             w_any;
  logic             w_load_ok;
  logic             w_xfer_in;
  logic [WIDTH-1:0] w_gdata;
  logic [N-1:0]     w_ready;
  logic [SW:0]      w_pos;

`ifdef NCHAN_MUX_ARB_RR_EN
  logic [SW-1:0] r_ptr;
  assign w_ptr = r_ptr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (w_xfer_in) begin
      if (w_gidx == SW'(N - 1)) r_ptr <= '0;
      else                      r_ptr <= w_gidx + 1'b1;
    end
  end
`else
  assign w_ptr = '0;
`endif

  // Walk ptr, ptr+1, ... modulo N; the first valid channel wins.
  always_comb begin
    w_any  = 1'b0;
    w_gidx = '0;
    w_pos  = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = {1'b0, w_ptr} + (SW + 1)'(k);
      if (w_pos >= (SW + 1)'(N)) w_pos = w_pos - (SW + 1)'(N);
      if (!w_any && in_valid[w_pos[SW-1:0]]) begin
        w_any  = 1'b1;
        w_gidx = w_pos[SW-1:0];
      end
    end
  end

  always_comb begin
    w_gdata = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gidx == SW'(i)) w_gdata = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign w_load_ok = !r_valid || out_ready;
  assign w_xfer_in = w_load_ok && w_any;

  always_comb begin
    w_ready = '0;
    for (int i = 0; i < N; i++) begin
      w_ready[i] = w_xfer_in && (w_gidx == SW'(i));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
    end else if (w_xfer_in) begin
      r_data  <= w_gdata;
      r_sel   <= w_gidx;
      r_valid <= 1'b1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign in_ready  = w_ready;
  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_nchan_mux_arb.sv
// tb_nchan_mux_arb: directed bench for nchan_mux_arb (N=4, WIDTH=8).
// Expected values follow the arbitration mode selected by NCHAN_MUX_ARB_RR_EN.
module tb_nchan_mux_arb;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_sel;

  int tests = 0;
  int fails = 0;

  nchan_mux_arb #(.N(4), .WIDTH(8)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v,
                         input logic [7:0] d, input logic [1:0] s);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".data"},  32'(out_data),  32'(d));
    check({tag, ".sel"},   32'(out_sel),   32'(s));
  endtask

`ifdef NCHAN_MUX_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic [1:0] seq_sel [6];
  logic [1:0] alt_sel [3];
  logic [1:0] wrp_sel [3];

  initial begin
    reset_n   = 1'b0;
    in_data   = '0;
    in_valid  = '0;
    out_ready = 1'b0;
    #1;
    chk_out("rst0", 1'b0, 8'h00, 2'd0);
    check("rst0.in_ready", 32'(in_ready), 32'h0);

    // Single channel
    @(negedge clock);
    reset_n   = 1'b1;
    in_valid  = 4'b0100;
    in_data   = 32'h00A5_0000;
    out_ready = 1'b1;
    #1;
    check("single.in_ready", 32'(in_ready), 32'b0100);
    tick();
    chk_out("single", 1'b1, 8'hA5, 2'd2);

    // Drain
    @(negedge clock);
    in_valid = 4'b0000;
    #1;
    check("drain.in_ready", 32'(in_ready), 32'h0);
    tick();
    chk_out("drain", 1'b0, 8'hA5, 2'd2);

    // Backpressure: load ch0 word then stall
    @(negedge clock);
    in_valid = 4'b0001;
    in_data  = 32'h0000_0011;
    tick();
    chk_out("bp.load", 1'b1, 8'h11, 2'd0);
    @(negedge clock);
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    in_data   = 32'h2322_2120;
    #1;
    check("bp.in_ready", 32'(in_ready), 32'h0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_out("bp.hold", 1'b1, 8'h11, 2'd0);
      check("bp.hold.in_ready", 32'(in_ready), 32'h0);
    end
    @(negedge clock);
    out_ready = 1'b1;
    #1;
    // RR pointer is 1 after the ch0 load; fixed priority picks ch0.
    check("bp.resume.in_ready", 32'(in_ready), RR ? 32'b0010 : 32'b0001);
    tick();
    chk_out("bp.resume", 1'b1, RR ? 8'h21 : 8'h20, RR ? 2'd1 : 2'd0);

    // Mid-run reset with a word held
    @(negedge clock);
    out_ready = 1'b0;
    #1;
    check("mrst.pre.valid", 32'(out_valid), 32'h1);
    reset_n = 1'b0;
    #1;
    chk_out("mrst.async", 1'b0, 8'h00, 2'd0);
    check("mrst.in_ready", 32'(in_ready), 32'b0001);
    out_ready = 1'b1;
    tick();
    chk_out("mrst.edge", 1'b0, 8'h00, 2'd0);

    // Release: all channels valid, full throughput
    @(negedge clock);
    reset_n = 1'b1;
    seq_sel = RR ? '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1}
                 : '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    for (int c = 0; c < 6; c++) begin
      tick();
      chk_out("all", 1'b1, 8'h20 + 8'(seq_sel[c]), seq_sel[c]);
    end

    // in_valid 1010: fixed always ch1; RR from ptr 2 alternates 3,1,3
    @(negedge clock);
    in_valid = 4'b1010;
    alt_sel = RR ? '{2'd3, 2'd1, 2'd3} : '{2'd1, 2'd1, 2'd1};
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_out("alt", 1'b1, 8'h20 + 8'(alt_sel[c]), alt_sel[c]);
    end

    // Move RR pointer to 3 via ch2, then wrap over 0011
    @(negedge clock);
    in_valid = 4'b0100;
    tick();
    chk_out("ptr3", 1'b1, 8'h22, 2'd2);
    @(negedge clock);
    in_valid = 4'b0011;
    #1;
    check("wrap.in_ready", 32'(in_ready), 32'b0001);
    wrp_sel = RR ? '{2'd0, 2'd1, 2'd0} : '{2'd0, 2'd0, 2'd0};
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_out("wrap", 1'b1, 8'h20 + 8'(wrp_sel[c]), wrp_sel[c]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nchan_mux_arb.md
NCHAN_MUX_ARB -- requirements
Module: nchan_mux_arb

Interface
REQ-001 Parameter N, default 4, number of input channels (2..16).
REQ-002 Parameter WIDTH, default 8, data width per channel.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  N  channel i holds valid data.
REQ-008 in_ready  output  N  channel i transfers this cycle; one-hot or zero.
REQ-009 out_data  output  WIDTH  registered selected data.
REQ-010 out_valid  output  1  out_data/out_sel hold a word.
REQ-011 out_ready  input  1  downstream accepts a word.
REQ-012 out_sel  output  max(1,$clog2(N))  index of the channel that supplied out_data.

Function
REQ-013 Input transfer on channel i SHALL occur when in_valid[i] && in_ready[i] at a rising clock edge; output transfer when out_valid && out_ready.
REQ-014 load_ok = !out_valid || out_ready; in_ready SHALL be zero when load_ok is 0.
REQ-015 When load_ok is 1 and any in_valid is set, exactly one in_ready bit SHALL be set: the granted channel per REQ-021/REQ-022.
REQ-016 in_ready SHALL be combinational from in_valid, out_valid, out_ready and the pointer; in_ready[i] SHALL never be set while in_valid[i] is 0.
REQ-017 On input transfer from channel g: out_data <= in_data[g], out_sel <= g, out_valid <= 1 on the same edge; latency 1 cycle.
REQ-018 On output transfer with no input transfer, out_valid SHALL clear on that edge; out_data/out_sel hold.
REQ-019 Simultaneous output and input transfer SHALL replace the word with no bubble (full throughput: one word per cycle).
REQ-020 While out_valid && !out_ready, out_data, out_sel and out_valid SHALL hold stable.
REQ-021 Grant search SHALL start at pointer ptr and take the first valid channel in order ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap-around modulo N).
REQ-022 After each input transfer from channel g, ptr SHALL become (g+1) mod N; ptr SHALL not change without an input transfer.
REQ-023 A channel with in_valid asserted SHALL be granted within N input transfers (starvation freedom, RR mode only).

Reset
REQ-024 Assertion of reset_n low SHALL immediately force out_valid=0, out_data=0, out_sel=0, ptr=0, hence in_ready=0 is not required; in_ready follows REQ-014 with out_valid=0.
REQ-025 Reset asserted mid-transfer SHALL discard the held word; no transfer completes on an edge where reset_n is low.
REQ-026 Deassertion of reset_n SHALL take effect at the next rising clock edge with no extra idle cycles.

Configuration
REQ-027 Macro NCHAN_MUX_ARB_RR_EN defined: round-robin arbitration per REQ-021..REQ-023.
REQ-028 Macro NCHAN_MUX_ARB_RR_EN undefined: fixed priority, lowest-index valid channel wins; ptr SHALL be constant 0 and no pointer register synthesised; REQ-023 not applicable.

Verification (N=4, WIDTH=8)
REQ-029 Reset: reset_n=0 mid-run with out_valid=1 -> out_valid=0, out_data=8'h00, out_sel=0 immediately, before any clock edge.
REQ-030 Single channel: in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_sel=2.
REQ-031 Backpressure: out_valid=1, out_ready=0, in_valid=4'b1111 -> in_ready=4'b0000 and outputs hold for 5 cycles; out_ready=1 -> next word loads with no bubble.
REQ-032 RR (macro defined): in_valid=4'b1111 constant, out_ready=1, from reset -> out_sel sequence 0,1,2,3,0,1; one word per cycle.
REQ-033 RR wrap: ptr=3, in_valid=4'b0011 -> grant ch0, then ch1, then ch0 again.
REQ-034 Fixed priority (macro undefined): in_valid=4'b1010 constant, out_ready=1 -> out_sel always 1; ch3 never granted.
